text_writer: RTL

//  Sequences writes into the text-mode tile memory (char code per 8x8 cell) read by the font path.

---
 rtl/text_writer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/text_writer.sv
// ---------------------------------------------------------------------------
// text_writer
//   Sequences writes into the text-mode tile memory (one char code per 8x8
//   cell). It accepts a byte stream, keeps a text cursor, interprets the
//   control bytes CR/LF/BS/FF, and shares the single tile-RAM port with VGA
//   readout by writing only while activevideo is low.
//
// Handshake: a byte transfers on a px_clk rising edge where char_valid and
//   char_ready are both 1. char_ready depends only on the FSM state, never on
//   char_valid. A source that sees char_ready low must hold char_in and
//   char_valid until the transfer happens.
//
// Ports
//   px_clk        in   1       pixel clock, sole clock
//   rstn          in   1       asynchronous active-low reset
//   frame_tick    in   1       one-cycle pulse per frame (TEXT_WRITER_CURSOR_EN only)
//   cursor_blink  out  1       cursor blink phase      (TEXT_WRITER_CURSOR_EN only)
//   activevideo   in   1       1 = tile RAM owned by readout, no writes
//   char_in       in   8       input byte
//   char_valid    in   1       char_in valid
//   char_ready    out  1       block can accept a byte (state == IDLE)
//   wr_en         out  1       tile RAM write strobe, one cycle per cell
//   wr_addr       out  ADDR_W  tile address
//   wr_data       out  8       char code to store
//   cursor_x      out  CX_W    current column, 0..COLS-1
//   cursor_y      out  CY_W    current row, 0..ROWS-1
//   busy          out  1       1 while in WRITE or CLEAR
//
// Optional feature macro: TEXT_WRITER_CURSOR_EN adds the cursor blink logic
//   and its two ports. Without it the block has no blink logic.
// ---------------------------------------------------------------------------
module text_writer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 16,
    parameter int ADDR_W = 11,
    parameter int CX_W   = 7,
    parameter int CY_W   = 4
) (
    input  logic              px_clk,
    input  logic              rstn,
`ifdef TEXT_WRITER_CURSOR_EN
    input  logic              frame_tick,
    output logic              cursor_blink,
`endif
    input  logic              activevideo,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [CX_W-1:0]   cursor_x,
    output logic [CY_W-1:0]   cursor_y,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(COLS * ROWS - 1);
    localparam logic [CX_W-1:0]   X_MAX  = CX_W'(COLS - 1);
    localparam logic [CY_W-1:0]   Y_MAX  = CY_W'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic [ADDR_W-1:0] row_base;   // always cursor_y * COLS, kept incrementally
    logic [7:0]        char_q;

    assign char_ready = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            state    <= CLEAR;
            clr_addr <= '0;
            row_base <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            char_q   <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (char_valid) begin
                        case (char_in)
                            8'h0D: cursor_x <= '0;
                            8'h0A: begin
                                if (cursor_y == Y_MAX) begin
                                    cursor_y <= '0;
                                    row_base <= '0;
                                end else begin
                                    cursor_y <= cursor_y + CY_W'(1);
                                    row_base <= row_base + COLS_A;
                                end
                            end
                            // Backspace only moves the cursor; the cell keeps its char.
                            8'h08: begin
                                if (cursor_x != '0)
                                    cursor_x <= cursor_x - CX_W'(1);
                            end
                            8'h0C: begin
                                clr_addr <= '0;
                                state    <= CLEAR;
                            end
                            default: begin
                                char_q <= char_in;
                                state  <= WRITE;
                            end
                        endcase
                    end
                end

                WRITE: begin
                    // Readout owns the RAM while activevideo is high: hold.
                    if (!activevideo) begin
                        wr_en   <= 1'b1;
                        wr_addr <= row_base + ADDR_W'(cursor_x);
                        wr_data <= char_q;
                        if (cursor_x != X_MAX) begin
                            cursor_x <= cursor_x + CX_W'(1);
                        end else begin
                            cursor_x <= '0;
                            if (cursor_y == Y_MAX) begin
                                cursor_y <= '0;
                                row_base <= '0;
                            end else begin
                                cursor_y <= cursor_y + CY_W'(1);
                                row_base <= row_base + COLS_A;
                            end
                        end
                        state <= IDLE;
                    end
                end

                CLEAR: begin
                    if (!activevideo) begin
                        wr_en   <= 1'b1;
                        wr_addr <= clr_addr;
                        wr_data <= 8'h20;
                        if (clr_addr == LAST_A) begin
                            cursor_x <= '0;
                            cursor_y <= '0;
                            row_base <= '0;
                            state    <= IDLE;
                        end else begin
                            clr_addr <= clr_addr + ADDR_W'(1);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef TEXT_WRITER_CURSOR_EN
    // Blink phase flips every 30 frames; typing forces the cursor visible
    // and restarts the period so it does not vanish mid-keystroke.
    logic [4:0] blink_cnt;

    always_ff @(posedge px_clk or negedge rstn) begin
        if (!rstn) begin
            blink_cnt    <= '0;
            cursor_blink <= 1'b1;
        end else if (char_valid && char_ready) begin
            blink_cnt    <= '0;
            cursor_blink <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt == 5'd29) begin
                blink_cnt    <= '0;
                cursor_blink <= ~cursor_blink;
            end else begin
                blink_cnt <= blink_cnt + 5'd1;
            end
        end
    end
`endif

endmodule
